irrigation_sequencer: RTL

//  Top-level sequencer for the soil-moisture loop. Periodically triggers an ADC

---
 rtl/irrigation_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/irrigation_sequencer.sv
// Soil-moisture irrigation sequencer: periodic ADC measurement, hysteresis compare,
// bounded pump pulses with soak intervals, and ADC-timeout / pulse-limit fault.
module irrigation_sequencer #(
  parameter int ADC_W      = 10,
  parameter int SAMPLE_PER = 1000,
  parameter int ADC_TO     = 255,
  parameter int PULSE_LEN  = 500,
  parameter int SOAK_LEN   = 2000,
  parameter int MAX_PULSES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ADC_W-1:0] thr_low,
  input  logic [ADC_W-1:0] thr_high,
  input  logic             adc_done,
  input  logic [ADC_W-1:0] adc_data,
  output logic             adc_start,
  output logic             pump_on,
  output logic             busy,
  output logic             fault,
  output logic             fault_code,
  output logic [ADC_W-1:0] sample,
  output logic [2:0]       state
);

  localparam int MAX_AB  = (SAMPLE_PER > ADC_TO) ? SAMPLE_PER : ADC_TO;
  localparam int MAX_CD  = (PULSE_LEN > SOAK_LEN) ? PULSE_LEN : SOAK_LEN;
  localparam int MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;
  localparam int PCNT_W  = $clog2(MAX_PULSES + 1);

  localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(ADC_TO - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  SOAK_LAST  = CNT_W'(SOAK_LEN - 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(SAMPLE_PER - 1);
  localparam logic [PCNT_W-1:0] PULSE_MAX  = PCNT_W'(MAX_PULSES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MEASURE = 3'd1,
    S_EVAL    = 3'd2,
    S_PUMP    = 3'd3,
    S_SOAK    = 3'd4,
    S_WAIT    = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t            cur, nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PCNT_W-1:0] pulse_cnt, pulse_nxt;
  logic [ADC_W-1:0]  sample_nxt;
  logic              code_nxt;

  always_comb begin
    nxt        = cur;
    sample_nxt = sample;
    pulse_nxt  = pulse_cnt;
    code_nxt   = fault_code;
    case (cur)
      S_IDLE: begin
        nxt       = S_MEASURE;
        pulse_nxt = '0;
      end
      // a done coincident with adc_start (cnt == 0) is not a valid result
      S_MEASURE: begin
        if (cnt != '0 && adc_done) begin
          nxt        = S_EVAL;
          sample_nxt = adc_data;
        end else if (cnt == TO_LAST) begin
          nxt      = S_FAULT;
          code_nxt = 1'b0;
        end
      end
      S_EVAL: begin
        if (sample >= thr_high) begin
          nxt       = S_WAIT;
          pulse_nxt = '0;
        end else if (sample < thr_low || pulse_cnt != '0) begin
          if (pulse_cnt < PULSE_MAX) begin
            nxt = S_PUMP;
          end else begin
            nxt      = S_FAULT;
            code_nxt = 1'b1;
          end
        end else begin
          nxt = S_WAIT;
        end
      end
      S_PUMP:  if (cnt == PULSE_LAST) nxt = S_SOAK;
      S_SOAK:  if (cnt == SOAK_LAST)  nxt = S_MEASURE;
      S_WAIT:  if (cnt == WAIT_LAST)  nxt = S_MEASURE;
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_IDLE;
    endcase

    if (nxt == S_PUMP && cur != S_PUMP && pulse_cnt != PULSE_MAX)
      pulse_nxt = pulse_cnt + 1'b1;

    // dropping enable wins over everything, including a coincident adc_done
    if (!enable) begin
      nxt        = S_IDLE;
      sample_nxt = sample;
      pulse_nxt  = pulse_cnt;
      code_nxt   = fault_code;
    end

    if (nxt != cur)
      cnt_nxt = '0;
    else if (cur == S_IDLE || cur == S_FAULT)
      cnt_nxt = cnt;
    else
      cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= S_IDLE;
      cnt        <= '0;
      pulse_cnt  <= '0;
      sample     <= '0;
      fault_code <= 1'b0;
      adc_start  <= 1'b0;
      pump_on    <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      cur        <= nxt;
      cnt        <= cnt_nxt;
      pulse_cnt  <= pulse_nxt;
      sample     <= sample_nxt;
      fault_code <= code_nxt;
      adc_start  <= (nxt == S_MEASURE) && (cur != S_MEASURE);
      pump_on    <= (nxt == S_PUMP);
      busy       <= (nxt != S_IDLE) && (nxt != S_FAULT);
      fault      <= (nxt == S_FAULT);
    end
  end

  assign state = cur;

endmodule
